// File: rtl/lsu_mem_port.sv
// lsu_mem_port
// Data-memory responder for load/store instructions. It takes the effective
// byte address, store data and func3 width code from the decode stage, runs a
// single request/acknowledge transaction on the data bus, holds the fetch unit
// through stall while the access is outstanding, and returns the lane-aligned,
// sign/zero-extended load result for the rd write-back mux.
//
// Parameters
//   TIMEOUT_CYCLES  BUSY cycles to wait for busAck before aborting (1..65535)
//
// Optional build macro
//   MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses skip the
//                     bus entirely and raise a one-cycle misaligned pulse.
//                     When undefined, misaligned is tied low and the low
//                     address bits that do not fit the access width are ignored.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   memRead, memWrite      load / store request from the decoder
//   func3                  instruction[14:12] width/sign code
//   addr, storeData        effective byte address, rs2 data
//   stall                  holds pc while an access is pending
//   loadData, loadValid    extended load result and its one-cycle update strobe
//   busReq, busWe          bus request (held until busAck), write select
//   busAddr, busWdata      word address, lane-replicated store data
//   busBe                  byte enables
//   busRdata, busAck       read data and one-cycle completion strobe
//   busErr                 one-cycle pulse on bus timeout
//   misaligned             one-cycle pulse on a trapped misaligned access

module lsu_mem_port #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        stall,
  output logic [31:0] loadData,
  output logic        loadValid,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [31:0] busWdata,
  output logic [3:0]  busBe,
  input  logic [31:0] busRdata,
  input  logic        busAck,
  output logic        busErr,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] tmo_cnt;
  logic [1:0]  addr_lo;
  logic [2:0]  func3_q;
  logic        is_load;
  logic        req;
  logic        trap;

  // Byte enables for a store of the given width at the given lane.
  function automatic logic [3:0] store_be(input logic [2:0] f, input logic [1:0] lo);
    case (f)
      3'b000:  store_be = 4'b0001 << lo;
      3'b001:  store_be = lo[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Store data is replicated across all lanes so busBe alone selects the target.
  function automatic logic [31:0] store_wdata(input logic [2:0] f, input logic [31:0] sd);
    case (f)
      3'b000:  store_wdata = {4{sd[7:0]}};
      3'b001:  store_wdata = {2{sd[15:0]}};
      default: store_wdata = sd;
    endcase
  endfunction

  // Extract the addressed byte/half from the bus word and extend it.
  function automatic logic [31:0] load_fmt(input logic [2:0] f, input logic [1:0] lo,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lo, 3'b000} +: 8];
    h = lo[1] ? d[31:16] : d[15:0];
    case (f)
      3'b000:  load_fmt = {{24{b[7]}}, b};
      3'b001:  load_fmt = {{16{h[15]}}, h};
      3'b100:  load_fmt = {24'd0, b};
      3'b101:  load_fmt = {16'd0, h};
      default: load_fmt = d;
    endcase
  endfunction

  assign req = memRead | memWrite;

  // stall rises in the same cycle the request is presented so the pc never
  // advances past a load/store before it completes; forced low under reset.
  assign stall = rst_n & (((state == IDLE) & req) | (state == BUSY));

`ifdef MISALIGN_TRAP_EN
  logic mis_q;

  // Stores only know SB/SH/word; loads additionally have LBU/LHU.
  function automatic logic misalign_chk(input logic [2:0] f, input logic [1:0] lo,
                                        input logic st);
    if (f == 3'b000 || (!st && f == 3'b100))
      misalign_chk = 1'b0;
    else if (f == 3'b001 || (!st && f == 3'b101))
      misalign_chk = lo[0];
    else
      misalign_chk = (lo != 2'b00);
  endfunction

  assign trap       = req & misalign_chk(func3, addr[1:0], memWrite);
  assign misaligned = mis_q;
`else
  assign trap       = 1'b0;
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmo_cnt   <= 16'd0;
      addr_lo   <= 2'b00;
      func3_q   <= 3'b000;
      is_load   <= 1'b0;
      busReq    <= 1'b0;
      busWe     <= 1'b0;
      busAddr   <= 32'd0;
      busWdata  <= 32'd0;
      busBe     <= 4'b0000;
      loadData  <= 32'd0;
      loadValid <= 1'b0;
      busErr    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      // Status strobes are single-cycle; only the DONE entry sets them.
      loadValid <= 1'b0;
      busErr    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req) begin
            is_load <= ~memWrite;
            addr_lo <= addr[1:0];
            func3_q <= func3;
            tmo_cnt <= 16'd0;
            if (trap) begin
              // Misaligned access never reaches the bus.
              state <= DONE;
`ifdef MISALIGN_TRAP_EN
              mis_q <= 1'b1;
`endif
            end else begin
              busReq  <= 1'b1;
              busWe   <= memWrite;
              busAddr <= {addr[31:2], 2'b00};
              if (memWrite) begin
                busBe    <= store_be(func3, addr[1:0]);
                busWdata <= store_wdata(func3, storeData);
              end else begin
                busBe    <= 4'b1111;
              end
              state <= BUSY;
            end
          end
        end

        BUSY: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (busAck) begin
            busReq <= 1'b0;
            if (is_load) begin
              loadData  <= load_fmt(func3_q, addr_lo, busRdata);
              loadValid <= 1'b1;
            end
            state <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            busReq <= 1'b0;
            busErr <= 1'b1;
            state  <= DONE;
          end
        end

        // The same instruction is still on memRead/memWrite here; ignoring
        // it for one cycle guarantees one bus transaction per instruction.
        DONE: begin
          state <= IDLE;
        end

        default: begin
          state  <= IDLE;
          busReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;

  logic        clk;
  logic        rst_n;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        stall;
  logic [31:0] loadData;
  logic        loadValid;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busBe;
  logic [31:0] busRdata;
  logic        busAck;
  logic        busErr;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  lsu_mem_port #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .func3      (func3),
    .addr       (addr),
    .storeData  (storeData),
    .stall      (stall),
    .loadData   (loadData),
    .loadValid  (loadValid),
    .busReq     (busReq),
    .busWe      (busWe),
    .busAddr    (busAddr),
    .busWdata   (busWdata),
    .busBe      (busBe),
    .busRdata   (busRdata),
    .busAck     (busAck),
    .busErr     (busErr),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; memRead = 1'b0; memWrite = 1'b0; func3 = 3'b000;
    addr = 32'd0; storeData = 32'd0; busRdata = 32'd0; busAck = 1'b0;
    @(negedge clk);
    checks++; if ({busReq, busWe, loadValid, busErr, misaligned, stall} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000",
                         {busReq, busWe, loadValid, busErr, misaligned, stall});
    end
    checks++; if ({busAddr, busWdata, loadData, busBe} !== 100'd0) begin
      errors++; $display("FAIL reset_data: addr %h wdata %h ld %h be %b expected all zero",
                         busAddr, busWdata, loadData, busBe);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busReq !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busreq: got %b expected 0", busReq);
    end
  endtask

  task automatic test_store();
    @(posedge clk); #1;
    memWrite = 1'b1; func3 = 3'b000; addr = 32'h0000_1003; storeData = 32'h0000_00A5;
    @(negedge clk);
    checks++; if ({stall, busReq} !== 2'b10) begin
      errors++; $display("FAIL sb_idle: stall/busReq got %b expected 10", {stall, busReq});
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (busAddr !== 32'h0000_1000) begin
      errors++; $display("FAIL sb_addr: got %h expected 00001000", busAddr);
    end
    checks++; if (busBe !== 4'b1000) begin
      errors++; $display("FAIL sb_be: got %b expected 1000", busBe);
    end
    checks++; if (busWdata !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", busWdata);
    end
    checks++; if ({busWe, busReq, stall} !== 3'b111) begin
      errors++; $display("FAIL sb_busy1: we/req/stall got %b expected 111", {busWe, busReq, stall});
    end
    @(posedge clk); #1;
    busAck = 1'b1;
    @(negedge clk);
    checks++; if ({busReq, stall} !== 2'b11) begin
      errors++; $display("FAIL sb_busy2: req/stall got %b expected 11", {busReq, stall});
    end
    @(posedge clk); #1;
    busAck = 1'b0;
    @(negedge clk);
    checks++; if ({stall, busReq, loadValid} !== 3'b000) begin
      errors++; $display("FAIL sb_done: stall/req/lv got %b expected 000", {stall, busReq, loadValid});
    end
    @(posedge clk); #1;
    memWrite = 1'b0;
    @(negedge clk);
    checks++; if ({stall, busReq} !== 2'b00) begin
      errors++; $display("FAIL sb_after: stall/req got %b expected 00", {stall, busReq});
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3v [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  offv[5] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] expv[5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF,
                             32'h0000_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      memRead = 1'b1; func3 = f3v[i]; addr = 32'h0000_4000 + 32'(offv[i]);
      busRdata = 32'h80FF_7F01; busAck = 1'b0;
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin
        errors++; $display("FAIL ld%0d_idle_stall: got %b expected 1", i, stall);
      end
      @(posedge clk); #1;
      busAck = 1'b1;
      @(negedge clk);
      checks++; if ({busReq, busWe, busBe, busAddr} !== {1'b1, 1'b0, 4'b1111, 32'h0000_4000}) begin
        errors++; $display("FAIL ld%0d_bus: req %b we %b be %b addr %h expected 1 0 1111 00004000",
                           i, busReq, busWe, busBe, busAddr);
      end
      @(posedge clk); #1;
      busAck = 1'b0;
      @(negedge clk);
      checks++; if (loadData !== expv[i]) begin
        errors++; $display("FAIL ld%0d_data: got %h expected %h", i, loadData, expv[i]);
      end
      checks++; if ({loadValid, stall} !== 2'b10) begin
        errors++; $display("FAIL ld%0d_done: lv/stall got %b expected 10", i, {loadValid, stall});
      end
      @(posedge clk); #1;
      memRead = 1'b0;
      @(negedge clk);
      checks++; if (loadValid !== 1'b0) begin
        errors++; $display("FAIL ld%0d_pulse: loadValid got %b expected 0", i, loadValid);
      end
    end
  endtask

  task automatic test_timeout();
    int  nreq = 0;
    int  nerr = 0;
    int  nstall = 0;
    bit  seen = 1'b0;
    @(posedge clk); #1;
    memRead = 1'b1; func3 = 3'b010; addr = 32'h0000_5000;
    busRdata = 32'h1111_1111; busAck = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nreq   += int'(busReq);
      nerr   += int'(busErr);
      nstall += int'(stall);
      if (busErr === 1'b1) begin
        seen = 1'b1;
        checks++; if ({loadValid, stall} !== 2'b00) begin
          errors++; $display("FAIL tmo_done: lv/stall got %b expected 00", {loadValid, stall});
        end
        checks++; if (loadData !== 32'h80FF_7F01) begin
          errors++; $display("FAIL tmo_ldata: got %h expected 80ff7f01", loadData);
        end
      end
      @(posedge clk); #1;
      if (seen) memRead = 1'b0;
    end
    memRead = 1'b0;
    checks++; if (nreq != 4) begin
      errors++; $display("FAIL tmo_req_cycles: got %0d expected 4", nreq);
    end
    checks++; if (nerr != 1) begin
      errors++; $display("FAIL tmo_err_pulses: got %0d expected 1", nerr);
    end
    checks++; if (nstall != 5) begin
      errors++; $display("FAIL tmo_stall_cycles: got %0d expected 5", nstall);
    end
  endtask

  task automatic test_back_to_back();
    int nreq = 0;
    int nlv = 0;
    int nwr = 0;
    int phase = 0;
    bit st_acked = 1'b0;
    @(posedge clk); #1;
    memRead = 1'b1; memWrite = 1'b0; func3 = 3'b010; addr = 32'h0000_3000;
    busRdata = 32'h1234_5678; busAck = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      busAck = busReq;
      nreq += int'(busReq);
      if (loadValid === 1'b1) begin
        nlv++;
        checks++; if (loadData !== 32'h1234_5678) begin
          errors++; $display("FAIL b2b_ldata: got %h expected 12345678", loadData);
        end
      end
      if (busReq === 1'b1 && busWe === 1'b1) begin
        nwr++;
        checks++; if ({busAddr, busWdata, busBe} !== {32'h0000_3004, 32'hDEAD_BEEF, 4'b1111}) begin
          errors++; $display("FAIL b2b_store: addr %h wdata %h be %b expected 00003004 deadbeef 1111",
                             busAddr, busWdata, busBe);
        end
      end
      @(posedge clk); #1;
      if (phase == 0 && nlv == 1) begin
        phase = 1;
        memRead = 1'b0; memWrite = 1'b1; func3 = 3'b010;
        addr = 32'h0000_3004; storeData = 32'hDEAD_BEEF;
      end else if (phase == 1 && nwr == 1 && !st_acked) begin
        st_acked = 1'b1;
      end else if (phase == 1 && st_acked) begin
        phase = 2;
        memWrite = 1'b0;
      end
    end
    memRead = 1'b0; memWrite = 1'b0; busAck = 1'b0;
    checks++; if (nreq != 2) begin
      errors++; $display("FAIL b2b_req_cycles: got %0d expected 2", nreq);
    end
    checks++; if (nlv != 1) begin
      errors++; $display("FAIL b2b_lv_pulses: got %0d expected 1", nlv);
    end
    checks++; if (nwr != 1) begin
      errors++; $display("FAIL b2b_write_cycles: got %0d expected 1", nwr);
    end
  endtask

  task automatic test_misalign();
    @(posedge clk); #1;
    memRead = 1'b1; func3 = 3'b010; addr = 32'h0000_2002;
    busRdata = 32'hCAFE_BABE; busAck = 1'b0;
    @(negedge clk);
    checks++; if ({stall, busReq} !== 2'b10) begin
      errors++; $display("FAIL mis_idle: stall/req got %b expected 10", {stall, busReq});
    end
`ifdef MISALIGN_TRAP_EN
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({misaligned, stall, loadValid, busReq} !== 4'b1000) begin
      errors++; $display("FAIL mis_trap_done: mis/stall/lv/req got %b expected 1000",
                         {misaligned, stall, loadValid, busReq});
    end
    checks++; if (loadData !== 32'h1234_5678) begin
      errors++; $display("FAIL mis_trap_ldata: got %h expected 12345678", loadData);
    end
    @(posedge clk); #1;
    memRead = 1'b0;
    @(negedge clk);
    checks++; if ({misaligned, busReq} !== 2'b00) begin
      errors++; $display("FAIL mis_trap_after: mis/req got %b expected 00", {misaligned, busReq});
    end
`else
    @(posedge clk); #1;
    busAck = 1'b1;
    @(negedge clk);
    checks++; if ({busReq, busBe, busAddr} !== {1'b1, 4'b1111, 32'h0000_2000}) begin
      errors++; $display("FAIL mis_plain_bus: req %b be %b addr %h expected 1 1111 00002000",
                         busReq, busBe, busAddr);
    end
    @(posedge clk); #1;
    busAck = 1'b0;
    @(negedge clk);
    checks++; if ({loadValid, misaligned} !== 2'b10) begin
      errors++; $display("FAIL mis_plain_done: lv/mis got %b expected 10", {loadValid, misaligned});
    end
    checks++; if (loadData !== 32'hCAFE_BABE) begin
      errors++; $display("FAIL mis_plain_ldata: got %h expected cafebabe", loadData);
    end
    @(posedge clk); #1;
    memRead = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_busy();
    @(posedge clk); #1;
    memRead = 1'b1; func3 = 3'b010; addr = 32'h0000_6000; busAck = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (busReq !== 1'b1) begin
      errors++; $display("FAIL rst_pre_busy: busReq got %b expected 1", busReq);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({busReq, stall} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_ctrl: req/stall got %b expected 00", {busReq, stall});
    end
    checks++; if (loadData !== 32'd0) begin
      errors++; $display("FAIL rst_mid_ldata: got %h expected 00000000", loadData);
    end
    memRead = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({busReq, loadValid, stall} !== 3'b000) begin
      errors++; $display("FAIL rst_release: req/lv/stall got %b expected 000", {busReq, loadValid, stall});
    end
    // A fresh LBU proves the FSM came back in IDLE.
    @(posedge clk); #1;
    memRead = 1'b1; func3 = 3'b100; addr = 32'h0000_6001; busRdata = 32'h0000_AB00;
    @(posedge clk); #1;
    busAck = 1'b1;
    @(posedge clk); #1;
    busAck = 1'b0;
    @(negedge clk);
    checks++; if ({loadValid, loadData} !== {1'b1, 32'h0000_00AB}) begin
      errors++; $display("FAIL rst_reuse: lv %b data %h expected 1 000000ab", loadValid, loadData);
    end
    @(posedge clk); #1;
    memRead = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store();
    test_load_ext();
    test_timeout();
    test_back_to_back();
    test_misalign();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
